// File: rtl/dsp_pkg.sv
// Shared DSP definitions: loader state encoding plus the instruction word and
// fetch address widths used by both the fetch stage and the imem loader.
package dsp_pkg;

   localparam int INSTR_W        = 32;
   localparam int IMEM_ADDR_W    = 16;
   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CHECK,
      ST_DONE
   } state_e;

endpackage

// File: rtl/dsp_word_packer.sv
// Little-endian byte-to-word assembler: the first byte of a word ends up in
// bits [7:0]; word_valid_o pulses for one cycle after the last byte is taken.
module dsp_word_packer
   import dsp_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               byte_en,
   input  logic [7:0]         byte_in,
   output logic [INSTR_W-1:0] word_o,
   output logic               word_valid_o,
   output logic               last_byte_o
);

   logic [INSTR_W-1:0]    word_q, word_d;
   logic [BYTE_IDX_W-1:0] idx_q, idx_d;
   logic                  valid_q, valid_d;

   assign last_byte_o  = byte_en && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
   assign word_o       = word_q;
   assign word_valid_o = valid_q;

   always_comb begin
      word_d  = word_q;
      idx_d   = idx_q;
      valid_d = 1'b0;
      if (clr) begin
         idx_d = '0;
      end else if (byte_en) begin
         word_d  = {byte_in, word_q[INSTR_W-1:8]};
         idx_d   = idx_q + 1'b1;
         valid_d = last_byte_o;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         word_q  <= word_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/dsp_imem_loader.sv
// Instruction memory loader: streams LEN_LO, LEN_HI and 4*N bytes into imem and
// holds the DSP in reset until done. DSP_IMEM_LOADER_CHECKSUM_EN adds an XOR trailer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | after reset, waiting for start, DSP held
// ST_LEN_LO | expecting low byte of word count N
// ST_LEN_HI | expecting high byte of word count N
// ST_DATA   | assembling and writing data words
// ST_CHECK  | expecting the XOR trailer byte (checksum build only)
// ST_DONE   | load finished (ok or error), waiting for restart
module dsp_imem_loader
   import dsp_pkg::*;
#(
   parameter int                ADDR_W    = IMEM_ADDR_W,
   parameter int                DATA_W    = INSTR_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] write_addr_i,
   output logic [DATA_W-1:0] write_data_i,
   output logic              write_en_i,
   output logic              dsp_hold,
   output logic              busy,
   output logic              load_done,
   output logic              load_err,
   output logic [15:0]       words_loaded
);

   state_e            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       words_q, words_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              hold_q, hold_d;
   logic              accept, byte_en, clr, pk_last, finish;
`ifdef DSP_IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
   logic              err_q, err_d;
`endif

   // Once the final byte is taken, stop accepting while the last write drains.
   always_comb begin
      case (state_q)
         ST_LEN_LO, ST_LEN_HI, ST_CHECK: in_ready = 1'b1;
         ST_DATA:                        in_ready = (words_q != len_q);
         default:                        in_ready = 1'b0;
      endcase
   end

   assign accept  = in_valid && in_ready;
   assign byte_en = accept && (state_q == ST_DATA);
   assign clr     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   dsp_word_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .byte_en      (byte_en),
      .byte_in      (in_data),
      .word_o       (write_data_i),
      .word_valid_o (write_en_i),
      .last_byte_o  (pk_last)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      words_d = words_q;
      addr_d  = addr_q;
      busy_d  = busy_q;
      done_d  = done_q;
      hold_d  = hold_q;
      finish  = 1'b0;
`ifdef DSP_IMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_LEN_LO;
               len_d   = '0;
               words_d = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               hold_d  = 1'b1;
`ifdef DSP_IMEM_LOADER_CHECKSUM_EN
               err_d   = 1'b0;
`endif
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               len_d[7:0] = in_data;
               state_d    = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               len_d[15:8] = in_data;
               if ({in_data, len_q[7:0]} == 16'h0000) finish  = 1'b1;
               else                                   state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            // Count and address are captured with byte 3 so they line up with the write strobe.
            if (pk_last) begin
               words_d = words_q + 16'd1;
               addr_d  = BASE_ADDR + ADDR_W'(words_q);
            end
            if (write_en_i && (words_q == len_q)) finish = 1'b1;
         end
`ifdef DSP_IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (accept) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               if (in_data == csum_q) begin
                  done_d = 1'b1;
                  hold_d = 1'b0;
               end else begin
                  err_d  = 1'b1;
               end
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      if (finish) begin
`ifdef DSP_IMEM_LOADER_CHECKSUM_EN
         state_d = ST_CHECK;
`else
         state_d = ST_DONE;
         busy_d  = 1'b0;
         done_d  = 1'b1;
         hold_d  = 1'b0;
`endif
      end
`ifdef DSP_IMEM_LOADER_CHECKSUM_EN
      if (clr)                                 csum_d = '0;
      else if (accept && state_q != ST_CHECK)  csum_d = csum_q ^ in_data;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         words_q <= '0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hold_q  <= 1'b1;
`ifdef DSP_IMEM_LOADER_CHECKSUM_EN
         csum_q  <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         words_q <= words_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hold_q  <= hold_d;
`ifdef DSP_IMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
         err_q   <= err_d;
`endif
      end
   end

   assign write_addr_i = addr_q;
   assign dsp_hold     = hold_q;
   assign busy         = busy_q;
   assign load_done    = done_q;
   assign words_loaded = words_q;
`ifdef DSP_IMEM_LOADER_CHECKSUM_EN
   assign load_err     = err_q;
`else
   assign load_err     = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_imem_loader.sv
// Directed bench for dsp_imem_loader; images carry an XOR trailer only when
// DSP_IMEM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_dsp_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic [15:0] write_addr_i;
   logic [31:0] write_data_i;
   logic        write_en_i;
   logic        dsp_hold, busy, load_done, load_err;
   logic [15:0] words_loaded;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          last_wr_cyc = 0;
   int          done_cyc = 0;
   int          idle_accepts = 0;
   logic [7:0]  tb_xor = 8'h00;
   logic [15:0] wr_addr[$];
   logic [31:0] wr_data[$];

   dsp_imem_loader dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .write_addr_i (write_addr_i),
      .write_data_i (write_data_i),
      .write_en_i   (write_en_i),
      .dsp_hold     (dsp_hold),
      .busy         (busy),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (write_en_i) begin
         wr_addr.push_back(write_addr_i);
         wr_data.push_back(write_data_i);
         last_wr_cyc = cyc;
      end
      if (in_valid && in_ready && !busy) idle_accepts++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tb_xor = 8'h00;
      wr_addr.delete();
      wr_data.delete();
   endtask

   // Returns at the negedge before the transferring posedge, with in_valid still high.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
      tb_xor = tb_xor ^ b;
   endtask

   task automatic send_trailer();
`ifdef DSP_IMEM_LOADER_CHECKSUM_EN
      send_byte(tb_xor, 0);
`endif
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      in_valid = 1'b0;
      while (!(load_done || load_err) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check("done_timeout", 32'd0, 32'd1);
      done_cyc = cyc;
   endtask

   logic [7:0] img2 [10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                             8'hEF, 8'hBE, 8'hAD, 8'hDE};
   logic [7:0] img3 [14] = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                             8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
   logic [31:0] exp3 [3] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};

   initial begin
      // Reset and idle behaviour
      repeat (3) @(negedge clk);
      check("rst_hold", dsp_hold, 1'b1);
      check("rst_ready", in_ready, 1'b0);
      check("rst_wen", write_en_i, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", load_done, 1'b0);
      check("rst_err", load_err, 1'b0);
      check("rst_words", words_loaded, 16'd0);
      rst = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      repeat (6) @(negedge clk);
      in_valid = 1'b0;
      check("idle_no_accept", idle_accepts, 0);
      check("idle_no_write", wr_addr.size(), 0);
      check("idle_hold", dsp_hold, 1'b1);

      // Two-word image, back to back
      pulse_start();
      check("start_busy", busy, 1'b1);
      check("start_hold", dsp_hold, 1'b1);
      foreach (img2[i]) send_byte(img2[i], 0);
      send_trailer();
      wait_done();
      check("t2_nwr", wr_addr.size(), 2);
      if (wr_addr.size() == 2) begin
         check("t2_addr0", wr_addr[0], 16'h0000);
         check("t2_data0", wr_data[0], 32'h12345678);
         check("t2_addr1", wr_addr[1], 16'h0001);
         check("t2_data1", wr_data[1], 32'hDEADBEEF);
      end
`ifndef DSP_IMEM_LOADER_CHECKSUM_EN
      check("t2_done_lat", done_cyc - last_wr_cyc, 1);
`endif
      check("t2_done", load_done, 1'b1);
      check("t2_hold", dsp_hold, 1'b0);
      check("t2_busy", busy, 1'b0);
      check("t2_words", words_loaded, 16'd2);
      check("t2_err", load_err, 1'b0);

      // Empty image
      pulse_start();
      check("t3_hold_reasserted", dsp_hold, 1'b1);
      check("t3_done_cleared", load_done, 1'b0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
`ifdef DSP_IMEM_LOADER_CHECKSUM_EN
      send_trailer();
      wait_done();
`else
      @(negedge clk);
      in_valid = 1'b0;
`endif
      check("t3_done", load_done, 1'b1);
      check("t3_words", words_loaded, 16'd0);
      check("t3_nwr", wr_addr.size(), 0);
      check("t3_hold", dsp_hold, 1'b0);

      // Three-word image with random gaps and an ignored mid-load start
      pulse_start();
      foreach (img3[i]) begin
         send_byte(img3[i], int'($urandom_range(0, 3)));
         if (i == 6) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b0;
         end
      end
      send_trailer();
      wait_done();
      check("t4_nwr", wr_addr.size(), 3);
      if (wr_addr.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("t4_addr%0d", i), wr_addr[i], 16'(i));
            check($sformatf("t4_data%0d", i), wr_data[i], exp3[i]);
         end
      end
      check("t4_words", words_loaded, 16'd3);
      check("t4_done", load_done, 1'b1);

      // Reset mid-load after 5 data bytes
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("t5_wen", write_en_i, 1'b0);
      check("t5_hold", dsp_hold, 1'b1);
      check("t5_busy", busy, 1'b0);
      check("t5_ready", in_ready, 1'b0);
      check("t5_words", words_loaded, 16'd0);
      check("t5_nwr", wr_addr.size(), 1);
      if (wr_addr.size() == 1) check("t5_data0", wr_data[0], 32'h04030201);
      @(negedge clk);
      rst = 1'b0;
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hA1, 0);
      send_byte(8'hB2, 0);
      send_byte(8'hC3, 0);
      send_byte(8'hD4, 0);
      send_trailer();
      wait_done();
      check("t5_reload_nwr", wr_addr.size(), 1);
      if (wr_addr.size() == 1) begin
         check("t5_reload_addr", wr_addr[0], 16'h0000);
         check("t5_reload_data", wr_data[0], 32'hD4C3B2A1);
      end
      check("t5_reload_done", load_done, 1'b1);

`ifdef DSP_IMEM_LOADER_CHECKSUM_EN
      // Trailer good then bad
      pulse_start();
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0);
      send_byte(8'h33, 0); send_byte(8'h44, 0);
      send_byte(8'h45, 0);
      wait_done();
      check("t6_done", load_done, 1'b1);
      check("t6_err", load_err, 1'b0);
      pulse_start();
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0);
      send_byte(8'h33, 0); send_byte(8'h44, 0);
      send_byte(8'h00, 0);
      wait_done();
      check("t6_bad_err", load_err, 1'b1);
      check("t6_bad_done", load_done, 1'b0);
      check("t6_bad_hold", dsp_hold, 1'b1);
`endif

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dsp_imem_loader.md
Name: dsp_imem_loader

Overview:
- Writer side of the instruction memory bank that the DSP fetch stage reads.
- Accepts a byte stream from the host/receiver front end through a valid/ready handshake.
- Assembles the bytes into 32-bit instruction words and writes them sequentially into instruction memory.
- Holds the DSP core in reset until the program image is fully loaded.

Parameters:
- ADDR_W, 16, instruction memory address width (matches the fetch read address).
- DATA_W, 32, instruction word width; fixed at 4 bytes per word.
- BASE_ADDR, 16'h0000, first instruction memory address written.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE
- in_valid  input  1  byte on in_data is valid
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle when in_valid is also high
- write_addr_i  output  ADDR_W  instruction memory write address
- write_data_i  output  DATA_W  instruction memory write data
- write_en_i  output  1  instruction memory write strobe, one cycle per word
- dsp_hold  output  1  keeps the DSP core in reset while high
- busy  output  1  load in progress
- load_done  output  1  image loaded; held high until the next start
- load_err  output  1  image error; held high until the next start
- words_loaded  output  16  count of words written in the current or last load

Behaviour:
- Reset (async, rst=1): all outputs 0, except dsp_hold=1; state=IDLE.
- A byte transfers only on a cycle where in_valid and in_ready are both high.
- Stream format (little-endian): LEN_LO, LEN_HI (N = word count), then 4*N data bytes, byte 0 in bits [7:0].
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK (only with the optional feature), DONE.
- IDLE/DONE to LEN_LO on start. On start: clear load_done, load_err, words_loaded and the byte index; set dsp_hold=1 and busy=1.
- LEN_LO: capture N[7:0], go to LEN_HI.
- LEN_HI: capture N[15:8].
  - If N=0, go to DONE, or to CHECK when the optional feature is enabled.
  - Otherwise go to DATA.
- DATA: shift each byte into the word assembly register; the 2-bit byte index wraps 3 to 0.
  - On acceptance of byte 3, the next cycle presents write_en_i=1 for exactly one cycle, with write_data_i = the assembled word and write_addr_i = BASE_ADDR + words_loaded (mod 2^ADDR_W, so addresses wrap).
  - words_loaded increments in that same cycle.
- in_ready=1 in LEN_LO, LEN_HI, DATA and CHECK; 0 in IDLE and DONE.
- Back-to-back bytes are accepted at one per cycle; the registered write never stalls the stream.
- After the last word's write cycle: go to DONE, or to CHECK when the optional feature is enabled.
- Entering DONE: busy=0, load_done=1, dsp_hold=0. dsp_hold is released no earlier than the cycle after the final write_en_i.
- The DSP sees only fully written memory.
- start while busy is ignored. A start pulse in DONE restarts the load and reasserts dsp_hold in the next cycle.
- in_valid gaps of any length stall the assembly and lose no state.
- rst asserted mid-load aborts immediately: write_en_i drops asynchronously, no partial word is written, and dsp_hold=1.

Optional Feature:
- Macro: DSP_IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - A running XOR of all LEN and data bytes is kept.
  - CHECK accepts one trailing byte.
  - If the trailing byte equals the running XOR, go to DONE normally.
  - If it differs: load_err=1, load_done=0, dsp_hold stays 1, state goes to DONE.
- When not defined: no CHECK state and no trailing byte; load_err is tied 0.

Decomposition:
- Shared package dsp_pkg holds:
  - the state enum constants (IDLE..DONE);
  - INSTR_W=32 and IMEM_ADDR_W=16, shared with the fetch stage;
  - BYTES_PER_WORD=4.
- One natural sub-module: dsp_word_packer (byte-to-word shift register, byte index, word_valid pulse). The FSM, address counter and checksum stay in the top.

Test Plan:
- Reset then idle: dsp_hold=1, in_ready=0, write_en_i=0; bytes offered with no start are never accepted.
- start, then stream 02 00 | 78 56 34 12 | EF BE AD DE → writes 0x12345678@0x0000 and 0xDEADBEEF@0x0001; load_done=1 and dsp_hold=0 exactly one cycle after the second write.
- N=0 (00 00) → no write_en_i; load_done=1 and words_loaded=0 immediately after LEN_HI.
- Randomised in_valid gaps on a 3-word image plus a start pulse mid-load → identical writes; the mid-load start is ignored.
- rst asserted after 5 data bytes → outputs return to reset values and only word 0 was written; a reload afterwards completes correctly.
- With the checksum macro defined: image 01 00 11 22 33 44 plus trailing 0x45 → load_done=1. Trailing 0x00 instead → load_err=1 and dsp_hold=1.
